// File: rtl/mem_line_responder.sv
// Memory-side line responder: backing store serviced as whole-line bursts.
// Reads return a fixed-latency, ascending one-word-per-cycle burst.
// Writes are taken beat by beat and acknowledged with a wr_done pulse.
module mem_line_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int WORDS_PER_LINE = 4,
  parameter int READ_LATENCY   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wdata_valid,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ready,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  wr_done,
  output logic                  busy
);
  localparam int CW    = $clog2(WORDS_PER_LINE);
  localparam int OFF   = CW + 2;
  localparam int LW    = ADDR_WIDTH - OFF;
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [3:0]    LAT_INIT = 4'(READ_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RBURST, S_WBURST, S_WDONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_lat;
  logic [LW-1:0]         r_line;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_rdata_last;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [LW-1:0]         w_req_line;
  logic [OFF-1:0]        w_unused_offset;
  logic                  w_wbeat;

  // Offset bits inside the line are irrelevant: bursts always start at word 0.
  assign w_req_line      = req_addr[ADDR_WIDTH-1:OFF];
  assign w_unused_offset = req_addr[OFF-1:0];
  assign w_wbeat         = (r_state == S_WBURST) && wdata_valid;

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign wdata_ready = (r_state == S_WBURST);
  assign wr_done     = (r_state == S_WDONE);
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rdata_last  = r_rdata_last;

  // Store write port: no reset, so words from an aborted write burst persist.
  always_ff @(posedge clk) begin
    if (w_wbeat) r_mem[{r_line, r_cnt}] <= wdata;
  end

  // Control FSM; read data is registered on the edge that presents each beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_lat         <= '0;
      r_line        <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_line <= w_req_line;
          r_cnt  <= '0;
          if (req_write) begin
            r_state <= S_WBURST;
          end else if (READ_LATENCY == 0) begin
            // Zero latency: the first beat is read straight off the request.
            r_state       <= S_RBURST;
            r_rdata       <= r_mem[{w_req_line, CNT_ZERO}];
            r_rdata_valid <= 1'b1;
            r_rdata_last  <= 1'b0;
            r_cnt         <= CW'(1);
          end else begin
            r_state <= S_WAIT;
            r_lat   <= LAT_INIT;
          end
        end
        S_WAIT: if (r_lat <= 4'd1) begin
          r_state       <= S_RBURST;
          r_lat         <= '0;
          r_rdata       <= r_mem[{r_line, r_cnt}];
          r_rdata_valid <= 1'b1;
          r_rdata_last  <= 1'b0;
          r_cnt         <= r_cnt + 1'b1;
        end else begin
          r_lat <= r_lat - 1'b1;
        end
        S_RBURST: if (r_rdata_last) begin
          // Dead cycle after the final beat before the next request.
          r_state       <= S_IDLE;
          r_rdata_valid <= 1'b0;
          r_rdata_last  <= 1'b0;
        end else begin
          r_rdata      <= r_mem[{r_line, r_cnt}];
          r_rdata_last <= (r_cnt == CNT_LAST);
          r_cnt        <= r_cnt + 1'b1;
        end
        S_WBURST: if (wdata_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= S_WDONE;
        end
        S_WDONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: a latency-3 instance driven by
// scenario tasks, plus a latency-0 instance checked inline.
module tb_mem_line_responder;
  localparam int L = 3;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, wdata_valid;
  logic [11:0] req_addr;
  logic [31:0] wdata;
  logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy;
  logic [31:0] rdata;

  logic        b_req_valid, b_req_write, b_wdata_valid;
  logic [11:0] b_req_addr;
  logic [31:0] b_wdata;
  logic        b_req_ready, b_wdata_ready, b_rdata_valid, b_rdata_last, b_wr_done, b_busy;
  logic [31:0] b_rdata;

  mem_line_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WORDS_PER_LINE(W), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wdata_valid(wdata_valid),
    .wdata(wdata), .wdata_ready(wdata_ready), .rdata_valid(rdata_valid),
    .rdata(rdata), .rdata_last(rdata_last), .wr_done(wr_done), .busy(busy));

  mem_line_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WORDS_PER_LINE(W), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .wdata_valid(b_wdata_valid),
    .wdata(b_wdata), .wdata_ready(b_wdata_ready), .rdata_valid(b_rdata_valid),
    .rdata(b_rdata), .rdata_last(b_rdata_last), .wr_done(b_wr_done), .busy(b_busy));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic last; int cyc; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model [1024];
  int          cyc = 0;
  int          ncmp = 0;
  int          nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every read beat must match the head of the scoreboard, cycle included.
  always @(negedge clk) begin
    if (!rst && rdata_valid) begin
      ncmp++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_beat: data=%h cyc=%0d with nothing expected", rdata, cyc);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || rdata_last !== e.last || cyc !== e.cyc) begin
          nerr++;
          $display("FAIL rd_beat: got data=%h last=%b cyc=%0d, need data=%h last=%b cyc=%0d",
                   rdata, rdata_last, cyc, e.data, e.last, e.cyc);
        end
      end
    end
  end

  // Wait (bounded) for idle at a negedge, then return there.
  task automatic wait_ready();
    int n = 0;
    @(negedge clk); #1;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      ncmp++; nerr++;
      $display("FAIL ready_timeout: req_ready=%b, need 1", req_ready);
    end
  endtask

  task automatic push_line(input logic [11:0] addr, input int acc);
    exp_t x;
    for (int i = 0; i < W; i++) begin
      x.data = model[{addr[11:4], 2'(i)}];
      x.last = (i == W - 1);
      x.cyc  = acc + L + i;
      sb.push_back(x);
    end
  endtask

  task automatic do_read(input logic [11:0] addr);
    int acc;
    wait_ready();
    acc = cyc + 1;
    push_line(addr, acc);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    @(negedge clk); #1;
    req_valid = 1'b0;
    repeat (L + W - 1) @(negedge clk);
    #1;
    ncmp++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL rd_outstanding: %0d beats left, need 0", sb.size());
      sb.delete();
    end
    @(negedge clk); #1;
    ncmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rd_return_idle: req_ready=%b busy=%b, need 1/0", req_ready, busy);
    end
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [0:3][31:0] d, input logic [0:3][1:0] gap);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    @(negedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < int'(gap[i]); g++) begin
        wdata_valid = 1'b0; wdata = 32'hDEAD_0000;
        @(negedge clk); #1;
        ncmp++;
        if (wr_done !== 1'b0 || wdata_ready !== 1'b1) begin
          nerr++;
          $display("FAIL wr_gap: wr_done=%b wdata_ready=%b, need 0/1", wr_done, wdata_ready);
        end
      end
      wdata_valid = 1'b1; wdata = d[i];
      model[{addr[11:4], 2'(i)}] = d[i];
      @(negedge clk); #1;
      wdata_valid = 1'b0;
      ncmp++;
      if (wr_done !== (i == W - 1)) begin
        nerr++;
        $display("FAIL wr_done_beat%0d: wr_done=%b, need %b", i, wr_done, (i == W - 1));
      end
    end
    @(negedge clk); #1;
    ncmp++;
    if (wr_done !== 1'b0 || req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL wr_after_done: wr_done=%b req_ready=%b, need 0/1", wr_done, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; wdata_valid = 0; wdata = '0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_wdata_valid = 0; b_wdata = '0;
    repeat (2) @(negedge clk);
    ncmp++;
    if ({req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy} !== 6'b100000 || rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_outputs: rdy/wrdy/rv/rl/wd/busy=%b rdata=%h, need 100000/0",
               {req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy}, rdata);
    end
    ncmp++;
    if (b_req_ready !== 1'b1 || b_busy !== 1'b0 || b_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_lat0: req_ready=%b busy=%b rdata=%h, need 1/0/0", b_req_ready, b_busy, b_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    do_write(12'h020, {32'hC0, 32'hC1, 32'hC2, 32'hC3}, {2'd0, 2'd0, 2'd0, 2'd0});
    wait_ready();
    acc = cyc + 1;
    push_line(12'h020, acc);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h020;
    @(negedge clk); #1;
    req_valid = 1'b0;
    repeat (L + 2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    ncmp++;
    if (rdata_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_burst: rdata_valid=%b req_ready=%b busy=%b, need 0/1/0",
               rdata_valid, req_ready, busy);
    end
    ncmp++;
    if (sb.size() !== W - 2) begin
      nerr++;
      $display("FAIL reset_beats_before: %0d beats still queued, need %0d", sb.size(), W - 2);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    do_read(12'h020);
  endtask

  task automatic test_write_read();
    do_write(12'h104, {32'hA0, 32'hA1, 32'hA2, 32'hA3}, {2'd0, 2'd0, 2'd0, 2'd0});
    do_read(12'h10C);
  endtask

  task automatic test_gaps();
    do_write(12'h208, {32'h11, 32'h22, 32'h33, 32'h44}, {2'd0, 2'd1, 2'd2, 2'd0});
    do_read(12'h200);
  endtask

  task automatic test_busy();
    int acc;
    do_write(12'h300, {32'h70, 32'h71, 32'h72, 32'h73}, {2'd0, 2'd0, 2'd0, 2'd0});
    wait_ready();
    acc = cyc + 1;
    push_line(12'h104, acc);
    push_line(12'h300, acc + L + W + 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h104;
    @(negedge clk); #1;
    req_addr = 12'h304;
    for (int i = 0; i < L + W; i++) begin
      ncmp++;
      if (req_ready !== 1'b0) begin
        nerr++;
        $display("FAIL busy_ready_c%0d: req_ready=%b, need 0", i, req_ready);
      end
      @(negedge clk); #1;
    end
    ncmp++;
    if (req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL busy_first_idle: req_ready=%b, need 1", req_ready);
    end
    @(negedge clk); #1;
    req_valid = 1'b0;
    repeat (L + W) @(negedge clk);
    #1;
    ncmp++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL busy_outstanding: %0d beats left, need 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [0:3][31:0] d;
    logic [0:3][1:0] g;
    for (int k = 0; k < 3; k++) begin
      a = 12'($urandom_range(0, 4095));
      for (int i = 0; i < W; i++) begin
        d[i] = $urandom;
        g[i] = 2'($urandom_range(0, 1));
      end
      do_write(a, d, g);
      do_read(a ^ 12'h00C);
    end
  endtask

  task automatic test_lat0();
    @(negedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 12'h048;
    @(negedge clk); #1;
    b_req_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      b_wdata_valid = 1'b1; b_wdata = 32'h50 + i;
      @(negedge clk); #1;
    end
    b_wdata_valid = 1'b0;
    @(negedge clk); #1;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 12'h044;
    @(negedge clk); #1;
    b_req_valid = 1'b0;
    for (int i = 0; i <= W; i++) begin
      ncmp++;
      if (i < W) begin
        if (b_rdata_valid !== 1'b1 || b_rdata !== 32'h50 + i || b_rdata_last !== (i == W - 1)) begin
          nerr++;
          $display("FAIL lat0_beat%0d: valid=%b data=%h last=%b, need 1/%h/%b",
                   i, b_rdata_valid, b_rdata, b_rdata_last, 32'h50 + i, (i == W - 1));
        end
      end else if (b_rdata_valid !== 1'b0 || b_busy !== 1'b0) begin
        nerr++;
        $display("FAIL lat0_end: valid=%b busy=%b, need 0/0", b_rdata_valid, b_busy);
      end
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_write_read();
    test_gaps();
    test_busy();
    test_random();
    test_lat0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the cache refill/writeback interface: the data cache is the initiator; this block services whole-line reads and writes.
- Holds the backing data store, one word per address.
- Accepts one line request at a time over a valid/ready handshake.
- Read data returns as a fixed-latency, single-word-per-cycle burst; write data is accepted beat by beat and acknowledged with a done pulse.
- Sits below the pipelined core's data cache, replacing direct data_memory access on misses.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 12: byte-address width. Store depth is 2^(ADDR_WIDTH-2) words.
- WORDS_PER_LINE, 4: beats per line. Must be a power of 2, 2 or more.
- READ_LATENCY, 3: idle cycles between read acceptance and the first data beat. Range 0..15.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: cache presents a line request.
- req_ready, output, 1: responder can accept a request.
- req_write, input, 1: 1 = line write, 0 = line read. Sampled on acceptance.
- req_addr, input, ADDR_WIDTH: byte address. Offset bits below line size are ignored. Sampled on acceptance.
- wdata_valid, input, 1: write beat present.
- wdata, input, DATA_WIDTH: write beat data.
- wdata_ready, output, 1: responder accepts a write beat this cycle.
- rdata_valid, output, 1: read beat valid. No backpressure.
- rdata, output, DATA_WIDTH: read beat data.
- rdata_last, output, 1: marks the final read beat.
- wr_done, output, 1: one-cycle pulse after the final write beat is stored.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- States: IDLE, WAIT, RBURST, WBURST, WDONE.
- Reset (asynchronous, mid-operation included): state goes to IDLE; beat counter and latency counter clear to 0.
  - Outputs at reset: req_ready=1, wdata_ready=0, rdata_valid=0, rdata_last=0, wr_done=0, busy=0, rdata=0.
  - Store contents are not cleared.
  - Words already written by an aborted write burst remain written.
- req_ready equals (state==IDLE). A request is accepted on an edge where req_valid & req_ready are both high.
- On acceptance, the block latches:
  - line base = req_addr with the low log2(WORDS_PER_LINE)+2 bits zeroed;
  - req_write.
- Beats always run in ascending order from word 0 to word WORDS_PER_LINE-1 of the line. There is no critical-word-first ordering.
- Read path:
  - On acceptance, go to WAIT with the latency counter = READ_LATENCY. If READ_LATENCY=0, go directly to RBURST.
  - WAIT decrements each cycle and moves to RBURST when the counter reaches 1.
  - Timing for READ_LATENCY=L, acceptance at edge 0: WAIT occupies cycles 1..L; rdata_valid is high for exactly WORDS_PER_LINE consecutive cycles starting in cycle L+1.
  - rdata is a registered read of store[base+cnt].
  - rdata_last is high only with the final beat.
  - State returns to IDLE in the cycle after the last beat, so at least one dead cycle separates back-to-back requests.
- Write path:
  - On acceptance, go to WBURST. wdata_ready=1 throughout WBURST.
  - On each edge with wdata_valid & wdata_ready: store[base+cnt] <= wdata, then cnt increments.
  - Gaps (wdata_valid low) are allowed and stall the counter.
  - After the final beat, go to WDONE: wr_done=1 for that one cycle, then IDLE.
  - wdata_valid outside WBURST is ignored.
- The beat counter is log2(WORDS_PER_LINE) bits wide. It wraps to 0 on the final beat.
- Addresses never leave the line.
- The top-bit address wrap follows from the ADDR_WIDTH truncation.
- Request inputs are ignored while busy. No error signalling.

Test Plan:
1. Reset mid-RBURST:
   - Stimulus: assert rst asynchronously between edges during beat 2 of a read.
   - Response: rdata_valid=0 and req_ready=1 immediately.
   - Response: after release, a new read of 0x020 completes normally.
2. Line write then read, defaults:
   - Stimulus: write req_addr=0x104 with beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
   - Response: wr_done pulses in the cycle after the 4th beat.
   - Stimulus: read req_addr=0x10C, accepted at edge 0.
   - Response: rdata_valid in cycles 4–7 with data 0xA0..0xA3 (base 0x100); rdata_last only in cycle 7; req_ready high again in cycle 8.
3. Write with gaps:
   - Stimulus: beats 0x11, (gap), 0x22, (gap, gap), 0x33, 0x44.
   - Response: wr_done only after 0x44.
   - Response: a read-back returns 0x11,0x22,0x33,0x44.
4. READ_LATENCY=0 build:
   - Stimulus: read accepted at edge 0.
   - Response: rdata_valid in cycles 1–4; busy deasserts in cycle 5.
5. Request while busy:
   - Stimulus: hold req_valid high with a different address during a read burst.
   - Response: ignored (req_ready=0).
   - Response: the held request is accepted at the first IDLE cycle, and its data follows L cycles later.
